// File: rtl/mm_lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mm_lock_pkg
//  Brief    : Shared types and constants for the mm_lock keypad password lock.
//  Revision : 1.0  initial release
// ============================================================================
package mm_lock_pkg;

    // Lock operating modes
    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        CHG1     = 2'd2,
        CHG2     = 2'd3
    } lock_state_t;

    // Command key codes (0-9 are digits, F is ignored)
    localparam logic [3:0]  KEY_CONFIRM = 4'hA;
    localparam logic [3:0]  KEY_LOCK    = 4'hB;
    localparam logic [3:0]  KEY_CLEAR   = 4'hC;
    localparam logic [3:0]  KEY_CHG     = 4'hD;
    localparam logic [3:0]  KEY_SHOW    = 4'hE;

    // Factory password, 8 BCD digits
    localparam logic [31:0] DEFAULT_PW  = 32'h1234_5678;

    // True for the numeric keys 0-9
    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

endpackage : mm_lock_pkg
`default_nettype wire

// File: rtl/mm_lock.sv
`default_nettype none
// ============================================================================
//  Module   : mm_lock
//  Brief    : 8-digit keypad password lock. Builds digit entries on the display,
//             verifies/changes the password and drives status LEDs, an error
//             counter and timer start strobes.
//  Revision : 1.0  initial release
// ============================================================================
module mm_lock #(
    parameter logic [31:0] DEFAULT_PW = mm_lock_pkg::DEFAULT_PW
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_value,
    input  logic        key_valid,
    output logic [31:0] display_num,
    output logic        led1,
    output logic        led2,
    output logic        led3,
    output logic [31:0] error_count,
    output logic        start_count4,
    output logic        start_count5
);
    import mm_lock_pkg::*;

    localparam logic [31:0] c_err_max = 32'hFFFF_FFFF;

    lock_state_t r_state;
    logic [31:0] r_password;
    logic [31:0] r_temp_pw;
    logic [31:0] r_display;
    logic [31:0] r_err_cnt;
    logic        r_led1;
    logic        r_led2;
    logic        r_led3;
    logic        r_start4;
    logic        r_start5;

    // Keypress decode, FSM and all output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOCKED;
            r_password <= DEFAULT_PW;
            r_temp_pw  <= 32'd0;
            r_display  <= 32'd0;
            r_err_cnt  <= 32'd0;
            r_led1     <= 1'b0;
            r_led2     <= 1'b0;
            r_led3     <= 1'b0;
            r_start4   <= 1'b0;
            r_start5   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            r_start4 <= 1'b0;
            r_start5 <= 1'b0;
            if (key_valid) begin
                if (is_digit(key_value)) begin
                    // Oldest digit falls off the left end
                    r_display <= {r_display[27:0], key_value};
                    r_led2    <= 1'b0;
                end else begin
                    case (key_value)
                        KEY_CLEAR: begin
                            r_display <= 32'd0;
                            r_led2    <= 1'b0;
                        end
                        KEY_CONFIRM: begin
                            r_display <= 32'd0;
                            case (r_state)
                                LOCKED: begin
                                    if (r_display == r_password) begin
                                        r_state   <= UNLOCKED;
                                        r_led1    <= 1'b1;
                                        r_err_cnt <= 32'd0;
                                        r_led2    <= 1'b0;
                                        r_led3    <= 1'b0;
                                    end else begin
                                        if (r_err_cnt != c_err_max) begin
                                            r_err_cnt <= r_err_cnt + 32'd1;
                                        end
                                        r_led2   <= 1'b1;
                                        r_start4 <= 1'b1;
                                        // Alarm timer starts only on the 2->3 crossing
                                        if (r_err_cnt == 32'd2) begin
                                            r_start5 <= 1'b1;
                                        end
                                        if (r_err_cnt >= 32'd2) begin
                                            r_led3 <= 1'b1;
                                        end
                                    end
                                end
                                UNLOCKED: begin
                                end
                                CHG1: begin
                                    r_temp_pw <= r_display;
                                    r_state   <= CHG2;
                                end
                                CHG2: begin
                                    if (r_display == r_temp_pw) begin
                                        r_password <= r_temp_pw;
                                        r_led2     <= 1'b0;
                                    end else begin
                                        r_led2     <= 1'b1;
                                    end
                                    r_state <= UNLOCKED;
                                end
                                default: begin
                                end
                            endcase
                        end
                        KEY_LOCK: begin
                            if (r_state != LOCKED) begin
                                r_state   <= LOCKED;
                                r_led1    <= 1'b0;
                                r_display <= 32'd0;
                            end
                        end
                        KEY_CHG: begin
                            if (r_state == UNLOCKED) begin
                                r_state   <= CHG1;
                                r_display <= 32'd0;
                            end
                        end
                        KEY_SHOW: begin
                            if (r_state == UNLOCKED) begin
                                r_display <= r_password;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign display_num  = r_display;
    assign led1         = r_led1;
    assign led2         = r_led2;
    assign led3         = r_led3;
    assign error_count  = r_err_cnt;
    assign start_count4 = r_start4;
    assign start_count5 = r_start5;

endmodule : mm_lock
`default_nettype wire

// File: tb/tb_mm_lock.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mm_lock
//  Brief    : Self-checking bench for mm_lock: directed scenarios followed by
//             random keypresses against a behavioural lock model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mm_lock;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  key_value = 4'h0;
    logic        key_valid = 1'b0;
    logic [31:0] display_num;
    logic        led1, led2, led3;
    logic [31:0] error_count;
    logic        start_count4, start_count5;

    mm_lock dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_value    (key_value),
        .key_valid    (key_valid),
        .display_num  (display_num),
        .led1         (led1),
        .led2         (led2),
        .led3         (led3),
        .error_count  (error_count),
        .start_count4 (start_count4),
        .start_count5 (start_count5)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 locked, 1 open, 2 first new entry, 3 repeat entry
    int          m_mode;
    logic [31:0] m_pw, m_tmp, m_disp, m_err;
    logic        m_led2, m_alarm, m_s4, m_s5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pw    = 32'h1234_5678;
        m_tmp   = 32'd0;
        m_disp  = 32'd0;
        m_err   = 32'd0;
        m_led2  = 1'b0;
        m_alarm = 1'b0;
        m_s4    = 1'b0;
        m_s5    = 1'b0;
    endtask

    task automatic model_key(input logic v, input logic [3:0] k);
        m_s4 = 1'b0;
        m_s5 = 1'b0;
        if (v) begin
            if (k <= 4'd9) begin
                m_disp = m_disp * 16 + {28'd0, k};
                m_led2 = 1'b0;
            end else if (k == 4'hC) begin
                m_disp = 0;
                m_led2 = 1'b0;
            end else if (k == 4'hA) begin
                if (m_mode == 0) begin
                    if (m_disp == m_pw) begin
                        m_mode = 1; m_err = 0; m_led2 = 1'b0; m_alarm = 1'b0;
                    end else begin
                        if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
                        m_led2 = 1'b1;
                        m_s4   = 1'b1;
                        m_s5   = (m_err == 3);
                        if (m_err >= 3) m_alarm = 1'b1;
                    end
                end else if (m_mode == 2) begin
                    m_tmp  = m_disp;
                    m_mode = 3;
                end else if (m_mode == 3) begin
                    if (m_disp == m_tmp) begin
                        m_pw = m_tmp; m_led2 = 1'b0;
                    end else begin
                        m_led2 = 1'b1;
                    end
                    m_mode = 1;
                end
                m_disp = 0;
            end else if (k == 4'hB) begin
                if (m_mode != 0) begin
                    m_mode = 0; m_disp = 0;
                end
            end else if (k == 4'hD) begin
                if (m_mode == 1) begin
                    m_mode = 2; m_disp = 0;
                end
            end else if (k == 4'hE) begin
                if (m_mode == 1) m_disp = m_pw;
            end
        end
    endtask

    task automatic compare_all();
        check("display_num",  display_num,  m_disp);
        check("led1",         {31'd0, led1}, {31'd0, (m_mode != 0)});
        check("led2",         {31'd0, led2}, {31'd0, m_led2});
        check("led3",         {31'd0, led3}, {31'd0, m_alarm});
        check("error_count",  error_count,  m_err);
        check("start_count4", {31'd0, start_count4}, {31'd0, m_s4});
        check("start_count5", {31'd0, start_count5}, {31'd0, m_s5});
    endtask

    // One clock with the given key qualifier, then compare against the model
    task automatic step(input logic v, input logic [3:0] k);
        key_valid = v;
        key_value = k;
        @(posedge clk);
        #1;
        model_key(v, k);
        compare_all();
        key_valid = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        step(1'b1, k);
    endtask

    task automatic idle();
        step(1'b0, 4'h0);
    endtask

    task automatic type_digits(input logic [31:0] val);
        for (int i = 7; i >= 0; i--) begin
            press(val[i*4 +: 4]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        model_reset();
        check("rst_display", display_num, 32'd0);
        check("rst_errcnt",  error_count, 32'd0);
        check("rst_leds",    {29'd0, led1, led2, led3}, 32'd0);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        model_reset();
        do_reset();

        // Default password unlocks
        type_digits(32'h1234_5678);
        press(4'hA);
        check("unlock_led1", {31'd0, led1}, 32'd1);
        check("unlock_disp", display_num, 32'd0);

        press(4'h3);
        press(4'hC);
        check("clear_disp", display_num, 32'd0);

        // Successful password change
        press(4'hD);
        type_digits(32'h9876_5432);
        press(4'hA);
        type_digits(32'h9876_5432);
        press(4'hA);
        check("chg_led1", {31'd0, led1}, 32'd1);
        check("chg_led2", {31'd0, led2}, 32'd0);
        press(4'hE);
        check("show_pw", display_num, 32'h9876_5432);

        // Lock, then one wrong attempt
        press(4'hB);
        check("lock_led1", {31'd0, led1}, 32'd0);
        type_digits(32'h8765_4321);
        press(4'hA);
        check("wrong_led2", {31'd0, led2}, 32'd1);
        check("wrong_err",  error_count, 32'd1);
        check("wrong_s4",   {31'd0, start_count4}, 32'd1);
        idle();
        check("s4_one_cycle", {31'd0, start_count4}, 32'd0);
        press(4'hC);
        check("clr_led2", {31'd0, led2}, 32'd0);

        // Locked: D and E have no effect
        press(4'h5);
        press(4'hD);
        press(4'hE);
        check("locked_de", display_num, 32'h0000_0005);
        press(4'hC);

        // Reach alarm from a clean counter
        type_digits(32'h9876_5432);
        press(4'hA);
        press(4'hB);
        for (int i = 0; i < 3; i++) press(4'hA);
        check("alarm_err",  error_count, 32'd3);
        check("alarm_led3", {31'd0, led3}, 32'd1);
        check("alarm_s5",   {31'd0, start_count5}, 32'd1);
        idle();
        check("s5_one_cycle", {31'd0, start_count5}, 32'd0);
        press(4'hA);
        check("alarm_hold_s5", {31'd0, start_count5}, 32'd0);
        type_digits(32'h9876_5432);
        press(4'hA);
        check("alarm_clr_err",  error_count, 32'd0);
        check("alarm_clr_led3", {31'd0, led3}, 32'd0);

        // Mismatched repeat keeps old password
        press(4'hD);
        type_digits(32'h1111_1111);
        press(4'hA);
        type_digits(32'h2222_2222);
        press(4'hA);
        check("mismatch_led2", {31'd0, led2}, 32'd1);
        press(4'hB);
        type_digits(32'h9876_5432);
        press(4'hA);
        check("oldpw_unlocks", {31'd0, led1}, 32'd1);

        // Nine digits drop the oldest
        for (int d = 1; d <= 9; d++) press(d[3:0]);
        check("nine_digits", display_num, 32'h2345_6789);
        press(4'hC);

        // Reset in the middle of a change restores the factory password
        press(4'hD);
        type_digits(32'h1111_1111);
        press(4'hA);
        press(4'h1);
        press(4'h1);
        do_reset();
        type_digits(32'h1234_5678);
        press(4'hA);
        check("rst_default_pw", {31'd0, led1}, 32'd1);

        // Random keypresses against the model
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                press(4'($urandom_range(0, 9)));
            end else if (r < 50) begin
                type_digits(m_pw);
            end else if (r < 80) begin
                press(4'($urandom_range(10, 15)));
            end else if (r < 88) begin
                idle();
            end else if (r < 99) begin
                press(4'($urandom_range(0, 15)));
            end else begin
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case stimulus ever stalls
    initial begin
        #5_000_000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_mm_lock
`default_nettype wire
